// File: rtl/interp_line_sched_if.sv
// Line-scheduler bundle: start/done control, mux and filter handshake, buffer strobes.
// skip_v is present only when INTERP_SCHED_VSKIP_EN is defined.
interface interp_line_sched_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic              ext_valid;
  logic              ext_ready;
  logic              filter_ready;
  logic              select;
  logic              line_valid;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic              busy;
  logic              done;
`ifdef INTERP_SCHED_VSKIP_EN
  logic              skip_v;

  modport master (
    input  start, ext_valid, filter_ready, skip_v,
    output ext_ready, select, line_valid, buf_wr_en, buf_wr_addr,
           buf_rd_en, buf_rd_addr, busy, done
  );

  modport slave (
    output start, ext_valid, filter_ready, skip_v,
    input  ext_ready, select, line_valid, buf_wr_en, buf_wr_addr,
           buf_rd_en, buf_rd_addr, busy, done
  );
`else
  modport master (
    input  start, ext_valid, filter_ready,
    output ext_ready, select, line_valid, buf_wr_en, buf_wr_addr,
           buf_rd_en, buf_rd_addr, busy, done
  );

  modport slave (
    output start, ext_valid, filter_ready,
    input  ext_ready, select, line_valid, buf_wr_en, buf_wr_addr,
           buf_rd_en, buf_rd_addr, busy, done
  );
`endif
endinterface

// File: rtl/interp_line_sched.sv
// Two-pass interpolation scheduler: external lines -> filter -> buffer rows, then buffer
// columns -> filter. INTERP_SCHED_VSKIP_EN adds skip_v to bypass the column pass.
module interp_line_sched #(
  parameter int unsigned N_EXT_LINES = 11,
  parameter int unsigned N_BUF_COLS  = 8,
  parameter int unsigned FILT_LAT    = 4,
  parameter int unsigned ADDR_W      = 4
) (
  input logic                 clk,
  input logic                 rst,
  interp_line_sched_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StRead,
    StFlush,
    StFin
  } state_e;

  localparam logic [ADDR_W-1:0] LastRow = ADDR_W'(N_EXT_LINES - 1);
  localparam logic [ADDR_W-1:0] LastCol = ADDR_W'(N_BUF_COLS - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   ln_cnt_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [FILT_LAT-1:0] wr_pipe_q;
  logic                rd_en_q;
`ifdef INTERP_SCHED_VSKIP_EN
  logic                skip_q;
`endif

  logic accept;
  logic wr_en;
  logic rd_en;
  logic last_write;

  assign accept     = (state_q == StLoad) && bus.ext_valid && bus.filter_ready;
  assign wr_en      = wr_pipe_q[FILT_LAT-1];
  assign rd_en      = (state_q == StRead) && bus.filter_ready;
  assign last_write = wr_en && (wr_addr_q == LastRow);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ln_cnt_q  <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_pipe_q <= '0;
      rd_en_q   <= 1'b0;
`ifdef INTERP_SCHED_VSKIP_EN
      skip_q    <= 1'b0;
`endif
    end else begin
      // The pipe models the filter's fixed latency, so it shifts regardless of ready.
      wr_pipe_q <= FILT_LAT'({wr_pipe_q, accept});
      rd_en_q   <= rd_en;
      if (accept) ln_cnt_q  <= ln_cnt_q + 1'b1;
      if (wr_en)  wr_addr_q <= wr_addr_q + 1'b1;
      if (rd_en)  rd_addr_q <= rd_addr_q + 1'b1;

      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StLoad;
            ln_cnt_q  <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
`ifdef INTERP_SCHED_VSKIP_EN
            skip_q    <= bus.skip_v;
`endif
          end
        end
        StLoad: begin
          if (accept && (ln_cnt_q == LastRow)) state_q <= StDrain;
        end
        StDrain: begin
`ifdef INTERP_SCHED_VSKIP_EN
          if (last_write) state_q <= skip_q ? StFin : StRead;
`else
          if (last_write) state_q <= StRead;
`endif
        end
        StRead: begin
          if (rd_en && (rd_addr_q == LastCol)) state_q <= StFlush;
        end
        StFlush: state_q <= StFin;
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // rd_en_q is only ever set from READ, so it also covers the FLUSH column.
  always_comb begin
    bus.ext_ready   = (state_q == StLoad) && bus.filter_ready;
    bus.select      = (state_q == StLoad);
    bus.line_valid  = accept || rd_en_q;
    bus.buf_wr_en   = wr_en;
    bus.buf_wr_addr = wr_addr_q;
    bus.buf_rd_en   = rd_en;
    bus.buf_rd_addr = rd_addr_q;
    bus.busy        = (state_q != StIdle);
    bus.done        = (state_q == StFin);
  end

endmodule
